// File: rtl/rs_issue_sched.sv
// Reservation-station issue scheduler: holds decoded micro-ops, snoops the CDB
// for operand wakeups and issues the oldest ready ALU op and the in-order memory head.
module rs_issue_sched #(
    parameter int DEPTH = 8,
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             disp_valid,
    output logic             disp_ready,
    input  logic [2:0]       disp_alu_op,
    input  logic             disp_is_mem,
    input  logic             disp_mem_write,
    input  logic [TAG_W-1:0] disp_src1_tag,
    input  logic [TAG_W-1:0] disp_src2_tag,
    input  logic             disp_src1_rdy,
    input  logic             disp_src2_rdy,
    input  logic [TAG_W-1:0] disp_dest_tag,
    input  logic [31:0]      disp_imm,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    output logic             alu_valid,
    input  logic             alu_ready,
    output logic [2:0]       alu_op,
    output logic [TAG_W-1:0] alu_src1_tag,
    output logic [TAG_W-1:0] alu_src2_tag,
    output logic [TAG_W-1:0] alu_dest_tag,
    output logic [31:0]      alu_imm,
    output logic             mem_valid,
    input  logic             mem_ready,
    output logic             mem_write,
    output logic [TAG_W-1:0] mem_src1_tag,
    output logic [TAG_W-1:0] mem_src2_tag,
    output logic [TAG_W-1:0] mem_dest_tag,
    output logic [31:0]      mem_imm,
    output logic [$clog2(DEPTH):0] count
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [DEPTH-1:0] valid_reg;
    logic [DEPTH-1:0] is_mem_reg;
    logic [DEPTH-1:0] wr_reg;
    logic [DEPTH-1:0] r1_reg;
    logic [DEPTH-1:0] r2_reg;
    logic [2:0]       op_reg   [DEPTH];
    logic [TAG_W-1:0] s1_reg   [DEPTH];
    logic [TAG_W-1:0] s2_reg   [DEPTH];
    logic [TAG_W-1:0] dest_reg [DEPTH];
    logic [31:0]      imm_reg  [DEPTH];
    // age_reg[i][j] set means entry i is older than entry j
    logic [DEPTH-1:0] age_reg  [DEPTH];
    logic [DEPTH-1:0] age_col  [DEPTH];
    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    count_next;
    logic             alu_hold_reg;
    logic [DEPTH-1:0] alu_hold_sel_reg;

    logic [DEPTH-1:0] alu_cand;
    logic [DEPTH-1:0] alu_oldest;
    logic [DEPTH-1:0] alu_sel;
    logic [DEPTH-1:0] mem_all;
    logic [DEPTH-1:0] mem_head;
    logic [DEPTH-1:0] mem_sel;
    logic [DEPTH-1:0] free_sel;
    logic             disp_fire;
    logic             alu_fire;
    logic             mem_fire;

    assign alu_cand = valid_reg & ~is_mem_reg & r1_reg & r2_reg;
    assign mem_all  = valid_reg & is_mem_reg;

    genvar gi, gj;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            for (gj = 0; gj < DEPTH; gj++) begin : g_bit
                assign age_col[gi][gj] = age_reg[gj][gi];
            end
            assign alu_oldest[gi] = alu_cand[gi] && !(|(alu_cand & age_col[gi]));
            assign mem_head[gi]   = mem_all[gi] && !(|(mem_all & age_col[gi]));
        end
    endgenerate

    // A stalled ALU request stays pinned even if an older op wakes up meanwhile.
    assign alu_sel = alu_hold_reg ? alu_hold_sel_reg : alu_oldest;
    assign mem_sel = mem_head & r1_reg & r2_reg;

    assign alu_valid  = |alu_sel;
    assign mem_valid  = |mem_sel;
    assign disp_ready = (count_reg < FULL) && !flush;
    assign disp_fire  = disp_valid && disp_ready;
    assign alu_fire   = alu_valid && alu_ready;
    assign mem_fire   = mem_valid && mem_ready;
    assign count      = count_reg;
    assign count_next = count_reg + CW'(disp_fire) - CW'(alu_fire) - CW'(mem_fire);

    always_comb begin
        free_sel = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_reg[i]) begin
                free_sel    = '0;
                free_sel[i] = 1'b1;
            end
        end
    end

    // One-hot AND-OR muxes; payloads read zero when nothing is selected.
    always_comb begin
        alu_op       = '0;
        alu_src1_tag = '0;
        alu_src2_tag = '0;
        alu_dest_tag = '0;
        alu_imm      = '0;
        mem_write    = 1'b0;
        mem_src1_tag = '0;
        mem_src2_tag = '0;
        mem_dest_tag = '0;
        mem_imm      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            alu_op       = alu_op       | ({3{alu_sel[i]}} & op_reg[i]);
            alu_src1_tag = alu_src1_tag | ({TAG_W{alu_sel[i]}} & s1_reg[i]);
            alu_src2_tag = alu_src2_tag | ({TAG_W{alu_sel[i]}} & s2_reg[i]);
            alu_dest_tag = alu_dest_tag | ({TAG_W{alu_sel[i]}} & dest_reg[i]);
            alu_imm      = alu_imm      | ({32{alu_sel[i]}} & imm_reg[i]);
            mem_write    = mem_write    | (mem_sel[i] & wr_reg[i]);
            mem_src1_tag = mem_src1_tag | ({TAG_W{mem_sel[i]}} & s1_reg[i]);
            mem_src2_tag = mem_src2_tag | ({TAG_W{mem_sel[i]}} & s2_reg[i]);
            mem_dest_tag = mem_dest_tag | ({TAG_W{mem_sel[i]}} & dest_reg[i]);
            mem_imm      = mem_imm      | ({32{mem_sel[i]}} & imm_reg[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            valid_reg        <= '0;
            count_reg        <= '0;
            alu_hold_reg     <= 1'b0;
            alu_hold_sel_reg <= '0;
        end else begin
            count_reg        <= count_next;
            alu_hold_reg     <= alu_valid && !alu_ready;
            alu_hold_sel_reg <= alu_sel;
            for (int i = 0; i < DEPTH; i++) begin
                if (disp_fire && free_sel[i]) begin
                    valid_reg[i]  <= 1'b1;
                    op_reg[i]     <= disp_alu_op;
                    is_mem_reg[i] <= disp_is_mem;
                    wr_reg[i]     <= disp_mem_write;
                    s1_reg[i]     <= disp_src1_tag;
                    s2_reg[i]     <= disp_src2_tag;
                    dest_reg[i]   <= disp_dest_tag;
                    imm_reg[i]    <= disp_imm;
                    r1_reg[i]     <= disp_src1_rdy || (cdb_valid && cdb_tag == disp_src1_tag);
                    r2_reg[i]     <= disp_src2_rdy || (cdb_valid && cdb_tag == disp_src2_tag);
                    age_reg[i]    <= '0;
                end else begin
                    if ((alu_fire && alu_sel[i]) || (mem_fire && mem_sel[i]))
                        valid_reg[i] <= 1'b0;
                    if (cdb_valid && cdb_tag == s1_reg[i])
                        r1_reg[i] <= 1'b1;
                    if (cdb_valid && cdb_tag == s2_reg[i])
                        r2_reg[i] <= 1'b1;
                    if (disp_fire)
                        age_reg[i] <= (age_reg[i] & ~free_sel) | (free_sel & {DEPTH{valid_reg[i]}});
                end
            end
        end
    end
endmodule

// File: tb/tb_rs_issue_sched.sv
// Bench for rs_issue_sched: directed scenarios plus a randomized run checked
// against a program-order queue model of the station.
module tb_rs_issue_sched;
    localparam int DEPTH = 8;
    localparam int TAG_W = 6;

    logic             clk = 1'b0;
    logic             reset, flush, disp_valid, disp_ready;
    logic [2:0]       disp_alu_op;
    logic             disp_is_mem, disp_mem_write;
    logic [TAG_W-1:0] disp_src1_tag, disp_src2_tag, disp_dest_tag;
    logic             disp_src1_rdy, disp_src2_rdy;
    logic [31:0]      disp_imm;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic             alu_valid, alu_ready, mem_valid, mem_ready, mem_write;
    logic [2:0]       alu_op;
    logic [TAG_W-1:0] alu_src1_tag, alu_src2_tag, alu_dest_tag;
    logic [TAG_W-1:0] mem_src1_tag, mem_src2_tag, mem_dest_tag;
    logic [31:0]      alu_imm, mem_imm;
    logic [3:0]       count;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [2:0]       op;
        bit               mem;
        bit               wr;
        logic [TAG_W-1:0] s1, s2, dest;
        bit               r1, r2;
        logic [31:0]      imm;
        int               uid;
    } ent_t;

    ent_t q[$];
    int   lock_uid = -1;
    int   next_uid = 0;

    always #5 clk = ~clk;

    rs_issue_sched #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_alu_op(disp_alu_op), .disp_is_mem(disp_is_mem), .disp_mem_write(disp_mem_write),
        .disp_src1_tag(disp_src1_tag), .disp_src2_tag(disp_src2_tag),
        .disp_src1_rdy(disp_src1_rdy), .disp_src2_rdy(disp_src2_rdy),
        .disp_dest_tag(disp_dest_tag), .disp_imm(disp_imm),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_op(alu_op),
        .alu_src1_tag(alu_src1_tag), .alu_src2_tag(alu_src2_tag),
        .alu_dest_tag(alu_dest_tag), .alu_imm(alu_imm),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_write(mem_write),
        .mem_src1_tag(mem_src1_tag), .mem_src2_tag(mem_src2_tag),
        .mem_dest_tag(mem_dest_tag), .mem_imm(mem_imm),
        .count(count)
    );

    // Oldest ready ALU op in program order, unless a stalled request is pinned.
    function automatic int exp_alu();
        if (lock_uid >= 0)
            foreach (q[i]) if (q[i].uid == lock_uid) return i;
        foreach (q[i]) if (!q[i].mem && q[i].r1 && q[i].r2) return i;
        return -1;
    endfunction

    function automatic int exp_mem();
        foreach (q[i]) if (q[i].mem) return (q[i].r1 && q[i].r2) ? i : -1;
        return -1;
    endfunction

    task automatic clear_inputs();
        flush = 0; disp_valid = 0; disp_alu_op = 0; disp_is_mem = 0; disp_mem_write = 0;
        disp_src1_tag = 0; disp_src2_tag = 0; disp_src1_rdy = 0; disp_src2_rdy = 0;
        disp_dest_tag = 0; disp_imm = 0; cdb_valid = 0; cdb_tag = 0;
        alu_ready = 0; mem_ready = 0;
    endtask

    task automatic drive_disp(input logic [2:0] op, input bit m, input bit w,
                              input int s1, input bit r1, input int s2, input bit r2,
                              input int dest, input logic [31:0] imm);
        disp_valid = 1; disp_alu_op = op; disp_is_mem = m; disp_mem_write = w;
        disp_src1_tag = TAG_W'(s1); disp_src1_rdy = r1;
        disp_src2_tag = TAG_W'(s2); disp_src2_rdy = r2;
        disp_dest_tag = TAG_W'(dest); disp_imm = imm;
    endtask

    // Called at the negative edge: applies this cycle's inputs to the model, then clocks.
    task automatic advance();
        int   ai, mi;
        bit   afire, mfire, dfire;
        ent_t e;
        ai = exp_alu();
        mi = exp_mem();
        if (reset || flush) begin
            q.delete();
            lock_uid = -1;
        end else begin
            afire = (ai >= 0) && alu_ready;
            mfire = (mi >= 0) && mem_ready;
            dfire = disp_valid && (q.size() < DEPTH);
            lock_uid = (ai >= 0 && !alu_ready) ? q[ai].uid : -1;
            if (cdb_valid)
                foreach (q[i]) begin
                    if (q[i].s1 == cdb_tag) q[i].r1 = 1;
                    if (q[i].s2 == cdb_tag) q[i].r2 = 1;
                end
            if (afire && mfire) begin
                if (ai > mi) begin q.delete(ai); q.delete(mi); end
                else begin q.delete(mi); q.delete(ai); end
            end else if (afire) q.delete(ai);
            else if (mfire) q.delete(mi);
            if (dfire) begin
                e.op = disp_alu_op; e.mem = disp_is_mem; e.wr = disp_mem_write;
                e.s1 = disp_src1_tag; e.s2 = disp_src2_tag; e.dest = disp_dest_tag;
                e.imm = disp_imm; e.uid = next_uid++;
                e.r1 = disp_src1_rdy || (cdb_valid && cdb_tag == disp_src1_tag);
                e.r2 = disp_src2_rdy || (cdb_valid && cdb_tag == disp_src2_tag);
                q.push_back(e);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1; clear_inputs();
        @(negedge clk); advance();
        reset = 0;
        @(negedge clk);
        checks++;
        if ({count, alu_valid, mem_valid, disp_ready} !== {4'd0, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL reset_state: count=%0d alu_valid=%b mem_valid=%b disp_ready=%b want 0 0 0 1",
                     count, alu_valid, mem_valid, disp_ready);
        end
        checks++;
        if ({alu_op, alu_dest_tag, alu_imm, mem_dest_tag, mem_imm} !== '0) begin
            failures++;
            $display("FAIL reset_payload: alu_op=%0d alu_dest=%0d mem_dest=%0d want 0", alu_op, alu_dest_tag, mem_dest_tag);
        end
        advance();
        $display("test_reset done");
    endtask

    task automatic test_basic_add();
        clear_inputs();
        drive_disp(3'b000, 0, 0, 1, 1, 2, 1, 5, 32'h1234);
        @(negedge clk); advance();
        clear_inputs(); alu_ready = 1;
        @(negedge clk);
        checks++;
        if ({alu_valid, alu_op, alu_dest_tag, alu_imm, count} !== {1'b1, 3'b000, 6'd5, 32'h1234, 4'd1}) begin
            failures++;
            $display("FAIL add_issue: valid=%b op=%0d dest=%0d imm=%h count=%0d want 1 0 5 1234 1",
                     alu_valid, alu_op, alu_dest_tag, alu_imm, count);
        end
        advance();
        @(negedge clk);
        checks++;
        if ({count, alu_valid} !== {4'd0, 1'b0}) begin
            failures++;
            $display("FAIL add_free: count=%0d alu_valid=%b want 0 0", count, alu_valid);
        end
        advance();
        $display("test_basic_add done");
    endtask

    task automatic test_wakeup_order();
        clear_inputs(); alu_ready = 1;
        drive_disp(3'b001, 0, 0, 3, 0, 1, 1, 7, 32'd0);
        @(negedge clk); advance();
        drive_disp(3'b010, 0, 0, 1, 1, 2, 1, 8, 32'd0);
        @(negedge clk);
        checks++;
        if (alu_valid !== 1'b0) begin
            failures++; $display("FAIL wake_none: alu_valid=%b want 0", alu_valid);
        end
        advance();
        disp_valid = 0; cdb_valid = 1; cdb_tag = 6'd3;
        @(negedge clk);
        checks++;
        if ({alu_valid, alu_op, alu_dest_tag} !== {1'b1, 3'b010, 6'd8}) begin
            failures++;
            $display("FAIL wake_xor_first: valid=%b op=%0d dest=%0d want 1 2 8", alu_valid, alu_op, alu_dest_tag);
        end
        advance();
        cdb_valid = 0;
        @(negedge clk);
        checks++;
        if ({alu_valid, alu_op, alu_dest_tag} !== {1'b1, 3'b001, 6'd7}) begin
            failures++;
            $display("FAIL wake_sub_next: valid=%b op=%0d dest=%0d want 1 1 7", alu_valid, alu_op, alu_dest_tag);
        end
        advance();
        $display("test_wakeup_order done");
    endtask

    task automatic test_full();
        clear_inputs();
        for (int i = 0; i < DEPTH; i++) begin
            drive_disp(3'b000, 0, 0, 20 + i, 0, 1, 1, 30 + i, 32'(i));
            @(negedge clk); advance();
        end
        drive_disp(3'b000, 0, 0, 1, 1, 1, 1, 50, 32'd0);
        @(negedge clk);
        checks++;
        if ({count, disp_ready} !== {4'd8, 1'b0}) begin
            failures++; $display("FAIL full_state: count=%0d disp_ready=%b want 8 0", count, disp_ready);
        end
        cdb_valid = 1; cdb_tag = 6'd20; alu_ready = 1;
        advance();
        cdb_valid = 0;
        @(negedge clk);
        checks++;
        if ({alu_valid, alu_dest_tag, disp_ready, count} !== {1'b1, 6'd30, 1'b0, 4'd8}) begin
            failures++;
            $display("FAIL full_issue: valid=%b dest=%0d disp_ready=%b count=%0d want 1 30 0 8",
                     alu_valid, alu_dest_tag, disp_ready, count);
        end
        advance();
        disp_valid = 0;
        @(negedge clk);
        checks++;
        if ({disp_ready, count} !== {1'b1, 4'd7}) begin
            failures++; $display("FAIL full_freed: disp_ready=%b count=%0d want 1 7", disp_ready, count);
        end
        advance();
        flush = 1;
        @(negedge clk); advance();
        clear_inputs();
        $display("test_full done");
    endtask

    task automatic test_mem_order();
        clear_inputs(); mem_ready = 1;
        drive_disp(3'b000, 1, 0, 9, 0, 1, 1, 11, 32'd100);
        @(negedge clk); advance();
        drive_disp(3'b000, 1, 1, 2, 1, 3, 1, 12, 32'd104);
        @(negedge clk);
        checks++;
        if (mem_valid !== 1'b0) begin
            failures++; $display("FAIL mem_blocked1: mem_valid=%b want 0", mem_valid);
        end
        advance();
        disp_valid = 0; cdb_valid = 1; cdb_tag = 6'd9;
        @(negedge clk);
        checks++;
        if (mem_valid !== 1'b0) begin
            failures++; $display("FAIL mem_blocked2: mem_valid=%b want 0", mem_valid);
        end
        advance();
        cdb_valid = 0;
        @(negedge clk);
        checks++;
        if ({mem_valid, mem_write, mem_dest_tag, mem_imm} !== {1'b1, 1'b0, 6'd11, 32'd100}) begin
            failures++;
            $display("FAIL mem_lw: valid=%b write=%b dest=%0d imm=%0d want 1 0 11 100", mem_valid, mem_write, mem_dest_tag, mem_imm);
        end
        advance();
        @(negedge clk);
        checks++;
        if ({mem_valid, mem_write, mem_dest_tag, mem_imm} !== {1'b1, 1'b1, 6'd12, 32'd104}) begin
            failures++;
            $display("FAIL mem_sw: valid=%b write=%b dest=%0d imm=%0d want 1 1 12 104", mem_valid, mem_write, mem_dest_tag, mem_imm);
        end
        advance();
        @(negedge clk);
        checks++;
        if ({mem_valid, count} !== {1'b0, 4'd0}) begin
            failures++; $display("FAIL mem_empty: valid=%b count=%0d want 0 0", mem_valid, count);
        end
        advance();
        $display("test_mem_order done");
    endtask

    task automatic test_dispatch_bypass();
        clear_inputs(); alu_ready = 1;
        drive_disp(3'b100, 0, 0, 1, 1, 4, 0, 13, 32'd7);
        cdb_valid = 1; cdb_tag = 6'd4;
        @(negedge clk); advance();
        clear_inputs(); alu_ready = 1;
        @(negedge clk);
        checks++;
        if ({alu_valid, alu_op, alu_dest_tag} !== {1'b1, 3'b100, 6'd13}) begin
            failures++;
            $display("FAIL bypass: valid=%b op=%0d dest=%0d want 1 4 13", alu_valid, alu_op, alu_dest_tag);
        end
        advance();
        $display("test_dispatch_bypass done");
    endtask

    task automatic test_flush();
        clear_inputs();
        for (int i = 0; i < 6; i++) begin
            drive_disp(3'(i % 5), (i % 3) == 2, 0, 40, 0, 1, 1, 20 + i, 32'd0);
            @(negedge clk); advance();
        end
        drive_disp(3'b000, 0, 0, 1, 1, 1, 1, 33, 32'd0);
        flush = 1; cdb_valid = 1; cdb_tag = 6'd40;
        @(negedge clk);
        checks++;
        if ({count, disp_ready} !== {4'd6, 1'b0}) begin
            failures++; $display("FAIL flush_pre: count=%0d disp_ready=%b want 6 0", count, disp_ready);
        end
        advance();
        clear_inputs();
        @(negedge clk);
        checks++;
        if ({count, alu_valid, mem_valid, disp_ready} !== {4'd0, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL flush_post: count=%0d alu_valid=%b mem_valid=%b disp_ready=%b want 0 0 0 1",
                     count, alu_valid, mem_valid, disp_ready);
        end
        advance();
        $display("test_flush done");
    endtask

    task automatic test_reset_mid_stall();
        clear_inputs();
        drive_disp(3'b000, 0, 0, 1, 1, 2, 1, 21, 32'd0);
        @(negedge clk); advance();
        clear_inputs();
        @(negedge clk);
        checks++;
        if ({alu_valid, alu_dest_tag} !== {1'b1, 6'd21}) begin
            failures++; $display("FAIL stall_valid: valid=%b dest=%0d want 1 21", alu_valid, alu_dest_tag);
        end
        reset = 1;
        advance();
        reset = 0;
        @(negedge clk);
        checks++;
        if ({count, alu_valid, mem_valid, disp_ready} !== {4'd0, 1'b0, 1'b0, 1'b1}) begin
            failures++;
            $display("FAIL stall_reset: count=%0d alu_valid=%b mem_valid=%b disp_ready=%b want 0 0 0 1",
                     count, alu_valid, mem_valid, disp_ready);
        end
        advance();
        $display("test_reset_mid_stall done");
    endtask

    task automatic test_random();
        int ai, mi;
        for (int c = 0; c < 800; c++) begin
            clear_inputs();
            flush = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 99) < 65)
                drive_disp(3'($urandom_range(0, 4)), $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
                           $urandom_range(0, 7), 1'($urandom_range(0, 1)),
                           $urandom_range(0, 7), 1'($urandom_range(0, 1)),
                           $urandom_range(0, 63), $urandom);
            cdb_valid = 1'($urandom_range(0, 1));
            cdb_tag   = 6'($urandom_range(0, 7));
            alu_ready = ($urandom_range(0, 9) < 7);
            mem_ready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            ai = exp_alu();
            mi = exp_mem();
            checks++;
            if (count !== 4'(q.size()) || disp_ready !== ((q.size() < DEPTH) && !flush)) begin
                failures++;
                $display("FAIL rnd_count c=%0d: count=%0d disp_ready=%b want %0d %b", c, count, disp_ready,
                         q.size(), (q.size() < DEPTH) && !flush);
            end
            checks++;
            if (ai < 0) begin
                if ({alu_valid, alu_op, alu_src1_tag, alu_src2_tag, alu_dest_tag, alu_imm} !== '0) begin
                    failures++;
                    $display("FAIL rnd_alu c=%0d: valid=%b dest=%0d want idle", c, alu_valid, alu_dest_tag);
                end
            end else if ({alu_valid, alu_op, alu_src1_tag, alu_src2_tag, alu_dest_tag, alu_imm} !==
                         {1'b1, q[ai].op, q[ai].s1, q[ai].s2, q[ai].dest, q[ai].imm}) begin
                failures++;
                $display("FAIL rnd_alu c=%0d: valid=%b op=%0d s1=%0d s2=%0d dest=%0d imm=%h want 1 %0d %0d %0d %0d %h",
                         c, alu_valid, alu_op, alu_src1_tag, alu_src2_tag, alu_dest_tag, alu_imm,
                         q[ai].op, q[ai].s1, q[ai].s2, q[ai].dest, q[ai].imm);
            end
            checks++;
            if (mi < 0) begin
                if ({mem_valid, mem_write, mem_src1_tag, mem_src2_tag, mem_dest_tag, mem_imm} !== '0) begin
                    failures++;
                    $display("FAIL rnd_mem c=%0d: valid=%b dest=%0d want idle", c, mem_valid, mem_dest_tag);
                end
            end else if ({mem_valid, mem_write, mem_src1_tag, mem_src2_tag, mem_dest_tag, mem_imm} !==
                         {1'b1, q[mi].wr, q[mi].s1, q[mi].s2, q[mi].dest, q[mi].imm}) begin
                failures++;
                $display("FAIL rnd_mem c=%0d: valid=%b wr=%b s1=%0d s2=%0d dest=%0d imm=%h want 1 %b %0d %0d %0d %h",
                         c, mem_valid, mem_write, mem_src1_tag, mem_src2_tag, mem_dest_tag, mem_imm,
                         q[mi].wr, q[mi].s1, q[mi].s2, q[mi].dest, q[mi].imm);
            end
            advance();
        end
        $display("test_random done: cycles=800");
    endtask

    initial begin
        reset = 1;
        clear_inputs();
        @(posedge clk); #1;
        test_reset();
        test_basic_add();
        test_wakeup_order();
        test_full();
        test_mem_order();
        test_dispatch_bypass();
        test_flush();
        test_reset_mid_stall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
